// File: rtl/camellia_round_scheduler.sv
// Camellia-128 round sequencer: whitening, three passes through the shared six-round unit, FL layers.
// Optional decrypt key ordering is enabled by defining CAMELLIA_DECRYPT_EN.
module camellia_round_scheduler #(
  parameter int ROUND_LAT = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_blk,
  input  logic         dec,
  input  logic [63:0]  kw1,
  input  logic [63:0]  kw2,
  input  logic [63:0]  kw3,
  input  logic [63:0]  kw4,
  input  logic [63:0]  ke1,
  input  logic [63:0]  ke2,
  input  logic [63:0]  ke3,
  input  logic [63:0]  ke4,
  output logic [63:0]  dp_in_l,
  output logic [63:0]  dp_in_r,
  output logic [1:0]   dp_grp,
  output logic         dp_rev,
  input  logic [63:0]  dp_out_l,
  input  logic [63:0]  dp_out_r,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_blk,
  output logic         busy
);
  typedef enum logic [2:0] {IDLE, R0, R1, R2, OUT} state_t;

  localparam logic [3:0] LAT = 4'(ROUND_LAT);

  state_t      state, state_n;
  logic [3:0]  cnt;
  logic        sample;
  logic [63:0] wa, wb, fa, fb, fc, fd, wc, wd;
  logic [1:0]  grp_first, grp_last;
  logic        rev_in;

  function automatic logic [63:0] fl(input logic [63:0] x, input logic [63:0] k);
    logic [31:0] t, yl, yr;
    t  = x[63:32] & k[63:32];
    yr = x[31:0] ^ {t[30:0], t[31]};
    yl = x[63:32] ^ (yr | k[31:0]);
    return {yl, yr};
  endfunction

  function automatic logic [63:0] flinv(input logic [63:0] y, input logic [63:0] k);
    logic [31:0] t, xl, xr;
    xl = y[63:32] ^ (y[31:0] | k[31:0]);
    t  = xl & k[63:32];
    xr = y[31:0] ^ {t[30:0], t[31]};
    return {xl, xr};
  endfunction

  assign sample   = (cnt == LAT);
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

`ifdef CAMELLIA_DECRYPT_EN
  logic dec_q;

  always_ff @(posedge CLK) begin
    if (RST)                        dec_q <= 1'b0;
    else if (in_valid && in_ready)  dec_q <= dec;
  end

  // Pre-whitening happens on the accept edge, so it keys off the live dec input.
  assign wa        = dec   ? kw3 : kw1;
  assign wb        = dec   ? kw4 : kw2;
  assign fa        = dec_q ? ke4 : ke1;
  assign fb        = dec_q ? ke3 : ke2;
  assign fc        = dec_q ? ke2 : ke3;
  assign fd        = dec_q ? ke1 : ke4;
  assign wc        = dec_q ? kw1 : kw3;
  assign wd        = dec_q ? kw2 : kw4;
  assign grp_first = dec   ? 2'd2 : 2'd0;
  assign grp_last  = dec_q ? 2'd0 : 2'd2;
  assign rev_in    = dec;
`else
  logic unused_dec;
  assign unused_dec = dec;
  assign wa         = kw1;
  assign wb         = kw2;
  assign fa         = ke1;
  assign fb         = ke2;
  assign fc         = ke3;
  assign fd         = ke4;
  assign wc         = kw3;
  assign wd         = kw4;
  assign grp_first  = 2'd0;
  assign grp_last   = 2'd2;
  assign rev_in     = 1'b0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid)  state_n = R0;
      R0:      if (sample)    state_n = R1;
      R1:      if (sample)    state_n = R2;
      R2:      if (sample)    state_n = OUT;
      OUT:     if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Counter restarts on every state change, so each R state spans ROUND_LAT+1 cycles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= (state_n != state) ? 4'd0 : cnt + 4'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dp_in_l   <= '0;
      dp_in_r   <= '0;
      dp_grp    <= 2'd0;
      dp_rev    <= 1'b0;
      out_blk   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          dp_in_l <= in_blk[127:64] ^ wa;
          dp_in_r <= in_blk[63:0] ^ wb;
          dp_grp  <= grp_first;
          dp_rev  <= rev_in;
        end
        R0: if (sample) begin
          dp_in_l <= fl(dp_out_l, fa);
          dp_in_r <= flinv(dp_out_r, fb);
          dp_grp  <= 2'd1;
        end
        R1: if (sample) begin
          dp_in_l <= fl(dp_out_l, fc);
          dp_in_r <= flinv(dp_out_r, fd);
          dp_grp  <= grp_last;
        end
        R2: if (sample) begin
          out_blk   <= {dp_out_r ^ wc, dp_out_l ^ wd};
          out_valid <= 1'b1;
        end
        OUT: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_camellia_round_scheduler.sv
// Scoreboard bench for camellia_round_scheduler with a keyed stand-in for the six-round unit.
module tb_camellia_round_scheduler;
  localparam int RL = 3;
`ifdef CAMELLIA_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_blk = '0;
  logic         dec = 1'b0;
  logic [63:0]  kw [4];
  logic [63:0]  ke [4];
  logic [63:0]  sk [18];
  logic [63:0]  dp_in_l, dp_in_r, dp_out_l, dp_out_r;
  logic [1:0]   dp_grp;
  logic         dp_rev;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_blk;
  logic         busy;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  camellia_round_scheduler #(.ROUND_LAT(RL)) dut (
    .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(in_ready), .in_blk(in_blk), .dec(dec),
    .kw1(kw[0]), .kw2(kw[1]), .kw3(kw[2]), .kw4(kw[3]),
    .ke1(ke[0]), .ke2(ke[1]), .ke3(ke[2]), .ke4(ke[3]),
    .dp_in_l(dp_in_l), .dp_in_r(dp_in_r), .dp_grp(dp_grp), .dp_rev(dp_rev),
    .dp_out_l(dp_out_l), .dp_out_r(dp_out_r),
    .out_valid(out_valid), .out_ready(out_ready), .out_blk(out_blk), .busy(busy)
  );

  // Arbitrary keyed round function; any F keeps the Feistel invertible.
  function automatic logic [63:0] ff(input logic [63:0] x, input logic [63:0] k);
    logic [63:0] t;
    t = (x ^ k) * 64'h9E3779B97F4A7C15;
    return t ^ {t[23:0], t[63:24]} ^ (t >> 17);
  endfunction

  function automatic logic [63:0] fl(input logic [63:0] x, input logic [63:0] k);
    logic [31:0] t, yl, yr;
    t  = x[63:32] & k[63:32];
    yr = x[31:0] ^ ((t << 1) | (t >> 31));
    yl = x[63:32] ^ (yr | k[31:0]);
    return {yl, yr};
  endfunction

  function automatic logic [63:0] flinv(input logic [63:0] y, input logic [63:0] k);
    logic [31:0] t, xl, xr;
    xl = y[63:32] ^ (y[31:0] | k[31:0]);
    t  = xl & k[63:32];
    xr = y[31:0] ^ ((t << 1) | (t >> 31));
    return {xl, xr};
  endfunction

  // Stand-in six-round unit: subkeys K1..K6 of group g, optionally reversed.
  function automatic logic [127:0] six_round(input logic [127:0] x, input logic [1:0] g, input logic rev);
    logic [63:0] l, r, k;
    l = x[127:64];
    r = x[63:0];
    for (int i = 0; i < 6; i++) begin
      k = rev ? sk[6*g + 5 - i] : sk[6*g + i];
      if (i % 2 == 0) r = r ^ ff(l, k);
      else            l = l ^ ff(r, k);
    end
    return {l, r};
  endfunction

  logic [127:0] pipe [RL];
  always @(posedge clk) begin
    pipe[0] <= six_round({dp_in_l, dp_in_r}, dp_grp, dp_rev);
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign dp_out_l = pipe[RL-1][127:64];
  assign dp_out_r = pipe[RL-1][63:0];

  // Whole 18-round cipher as a single loop over the flattened key list.
  function automatic logic [127:0] ref_cipher(input logic [127:0] blk, input bit d);
    logic [63:0] l, r, k;
    int j, a, b;
    l = blk[127:64] ^ (d ? kw[2] : kw[0]);
    r = blk[63:0]   ^ (d ? kw[3] : kw[1]);
    for (int i = 0; i < 18; i++) begin
      if (i == 6 || i == 12) begin
        j = i / 6 - 1;
        a = d ? 3 - 2*j : 2*j;
        b = d ? 2 - 2*j : 2*j + 1;
        l = fl(l, ke[a]);
        r = flinv(r, ke[b]);
      end
      k = d ? sk[17 - i] : sk[i];
      if (i % 2 == 0) r = r ^ ff(l, k);
      else            l = l ^ ff(r, k);
    end
    return {r ^ (d ? kw[0] : kw[2]), l ^ (d ? kw[1] : kw[3])};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [127:0] exp;
    int           t;
    bit           d;
  } exp_t;
  exp_t sbq[$];

  int           last_acc = -1;
  bit           b2b_chk = 1'b0;
  logic         prev_ov = 1'b0;
  logic         prev_hold = 1'b0;
  logic [127:0] prev_blk = '0;
  int           dt, kgrp;
  exp_t         e;

  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      prev_ov   = 1'b0;
      prev_hold = 1'b0;
      last_acc  = -1;
    end else begin
      if (sbq.size() > 0 && !out_valid) begin
        dt = cyc - sbq[0].t;
        if (dt >= 1 && dt <= 3*RL + 3) begin
          kgrp = (dt - 1) / (RL + 1);
          check("dp_grp", {126'd0, dp_grp}, sbq[0].d ? 128'(2 - kgrp) : 128'(kgrp));
          check("dp_rev", {127'd0, dp_rev}, {127'd0, sbq[0].d});
        end
      end
      if (out_valid && !prev_ov) begin
        if (sbq.size() == 0) check("unexpected_out", 128'd1, 128'd0);
        else check("out_latency", 128'(cyc), 128'(sbq[0].t + 3*RL + 4));
      end
      if (prev_hold) begin
        check("hold_valid", {127'd0, out_valid}, 128'd1);
        check("hold_blk", out_blk, prev_blk);
      end
      if (out_valid) check("in_ready_out", {127'd0, in_ready}, 128'd0);
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) check("pop_empty", 128'd1, 128'd0);
        else begin
          e = sbq.pop_front();
          check("out_blk", out_blk, e.exp);
        end
      end
      if (in_valid && in_ready) begin
        if (b2b_chk && last_acc >= 0) check("b2b_spacing", 128'(cyc - last_acc), 128'(3*RL + 5));
        last_acc = cyc;
        e.d   = dec & DEC_EN;
        e.exp = ref_cipher(in_blk, dec & DEC_EN);
        e.t   = cyc;
        sbq.push_back(e);
      end
      prev_ov   = out_valid;
      prev_hold = out_valid && !out_ready;
      prev_blk  = out_blk;
    end
  end

  task automatic send(input logic [127:0] b, input bit d);
    int n;
    @(posedge clk); #1;
    in_blk = b; dec = d; in_valid = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 500) begin
        check("accept_timeout", 128'd1, 128'd0);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_blk = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sbq.size() != 0 || busy) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        check("drain_timeout", 128'd1, 128'd0);
        break;
      end
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 4; i++) begin
      kw[i] = {$urandom, $urandom};
      ke[i] = {$urandom, $urandom};
    end
    for (int i = 0; i < 18; i++) sk[i] = {$urandom, $urandom};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {127'd0, in_ready}, 128'd1);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_out_blk", out_blk, 128'd0);
    check("rst_dp_in", {dp_in_l, dp_in_r}, 128'd0);
    check("rst_dp_grp", {126'd0, dp_grp}, 128'd0);
    check("rst_dp_rev", {127'd0, dp_rev}, 128'd0);

    // Random blocks with random idle gaps, plus all-zero and all-one extremes.
    send('0, 1'b0);
    send('1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      send(rnd128(), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3 * RL + 8)) @(posedge clk);
    end
    wait_drain();

    // Back-to-back with in_valid re-offered immediately after each accept.
    last_acc = -1;
    b2b_chk = 1'b1;
    for (int i = 0; i < 3; i++) send(rnd128(), 1'($urandom_range(0, 1)));
    wait_drain();
    b2b_chk = 1'b0;

    // Consumer stall: output held while a second block is offered.
    @(posedge clk); #1 out_ready = 1'b0;
    send(rnd128(), 1'b1);
    n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    check("stall_out_valid", {127'd0, out_valid}, 128'd1);
    @(posedge clk); #1;
    in_blk = rnd128(); dec = 1'b0; in_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("stall_busy", {127'd0, busy}, 128'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_after_release", {127'd0, in_ready}, 128'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_drain();

    // Reset in the second cycle of R1 discards the block.
    send(rnd128(), 1'b0);
    repeat (RL + 2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", {127'd0, busy}, 128'd0);
    check("midrst_out_valid", {127'd0, out_valid}, 128'd0);
    check("midrst_dp_in", {dp_in_l, dp_in_r}, 128'd0);
    check("midrst_in_ready", {127'd0, in_ready}, 128'd1);
    send(rnd128(), 1'b1);
    wait_drain();

    // Reset and in_valid together: nothing accepted.
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; in_blk = rnd128();
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rst_vs_valid_busy", {127'd0, busy}, 128'd0);
    send(rnd128(), 1'b0);
    wait_drain();
    check("scoreboard_empty", 128'(sbq.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/camellia_round_scheduler.md
# camellia_round_scheduler

Sequencing controller for the Camellia-128 six-round Feistel datapath. It accepts one 128-bit block per handshake and applies pre-whitening. It then drives the shared six-round unit three times, selecting subkey group 0/1/2 and applying the FL/FL⁻¹ layer between passes. Finally it applies post-whitening with the final half swap and presents the ciphertext on a valid/ready output. It sits between the key schedule and the top-level cipher wrapper, and it is the only block that drives the six-round unit's inputs.

## Interface
- ROUND_LAT, 1: clock edges from `dp_in_l/r` stable to `dp_out_l/r` valid in the six-round unit; legal range 1–15.

Ports:
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- in_valid  in  1  input block offered
- in_ready  out  1  input accepted when `in_valid && in_ready`
- in_blk  in  128  plaintext; [127:64] is the left half
- dec  in  1  decrypt request, sampled at accept
- kw1, kw2, kw3, kw4  in  64 each  whitening keys
- ke1, ke2, ke3, ke4  in  64 each  FL-layer keys
- dp_in_l, dp_in_r  out  64 each  six-round unit inputs (registered)
- dp_grp  out  2  subkey group select for the K1..K6 mux: 0, 1, 2
- dp_rev  out  1  key mux presents the group in reverse order (decrypt)
- dp_out_l, dp_out_r  in  64 each  six-round unit outputs
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- out_blk  out  128  result; [127:64] is the left half
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, R0, R1, R2, OUT.
- `in_ready = (state == IDLE)`, combinational.
- **IDLE**, on accept:
  - `dp_in_l <= in_blk[127:64] ^ wa`
  - `dp_in_r <= in_blk[63:0] ^ wb`
  - latch `dec`; load counter to 0; go to R0 with `dp_grp = 0`.
- **Rk**: the counter increments each cycle. When counter == ROUND_LAT, sample `dp_out`:
  - R0 → R1: `dp_in_l <= FL(dp_out_l, fa)`, `dp_in_r <= FLINV(dp_out_r, fb)`, `dp_grp <= 1`.
  - R1 → R2: same, with keys fc and fd, `dp_grp <= 2`.
  - R2 → OUT: `out_blk <= {dp_out_r ^ wc, dp_out_l ^ wd}`; `out_valid <= 1`.
- Each R state reloads the counter to 0 on entry.
- **Encrypt key order**:
  - wa/wb = kw1/kw2; fa/fb = ke1/ke2; fc/fd = ke3/ke4; wc/wd = kw3/kw4.
  - `dp_rev = 0`.
- **FL(x, k)**, with xL/xR and kL/kR the 32-bit halves:
  - `yR = xR ^ rotl1(xL & kL)`
  - `yL = xL ^ (yR | kR)`
- **FLINV(y, k)**:
  - `xL = yL ^ (yR | kR)`
  - `xR = yR ^ rotl1(xL & kL)`
- **OUT**: `out_blk` and `out_valid` hold until `out_ready`. On `out_valid && out_ready`, drop `out_valid` and return to IDLE. There is no bypass: a new accept happens no earlier than the following cycle.
- Keys must stay stable from accept until output handshake. The block does not latch them.
- `in_valid` while busy is ignored (`in_ready = 0`). `in_blk` is not sampled.

## Timing
- Reset: takes effect on the RST edge and overrides any in-flight block; the next cycle is IDLE.
  - Reset values: `state = IDLE`, `out_valid = 0`, `out_blk = 0`, `dp_in_l = 0`, `dp_in_r = 0`, `dp_grp = 0`, `dp_rev = 0`, `busy = 0`.
  - `in_ready = 1` from the first cycle after RST deasserts.
  - A reset during Rk or OUT discards the block with no output handshake.
- Accept edge at end of cycle T: each R state lasts ROUND_LAT+1 cycles, and `out_valid` first rises in cycle T+3·ROUND_LAT+4.
- Back-to-back throughput with `out_ready` held high: one block per 3·ROUND_LAT+5 cycles.
- `dp_grp` and `dp_rev` change only on R-state transitions and are stable throughout each R state.
- Simultaneous `RST` and `in_valid`: reset wins and nothing is accepted.

## Configuration
- CAMELLIA_DECRYPT_EN defined:
  - If the latched `dec` = 1, the key order is wa/wb = kw3/kw4, fa/fb = ke4/ke3, fc/fd = ke2/ke1, wc/wd = kw1/kw2.
  - `dp_grp` sequences 2, 1, 0, and `dp_rev = 1` for the whole block.
- Not defined:
  - `dec` is ignored; encrypt order always; `dp_rev` is constant 0.

## Test plan
- Key 0123456789abcdeffedcba9876543210, ROUND_LAT=1, encrypt `in_blk`=0123456789abcdeffedcba9876543210 → `out_blk`=67673138549669730857065648eabe43 with `out_valid` in cycle T+7.
- With CAMELLIA_DECRYPT_EN, `dec`=1, `in_blk`=67673138549669730857065648eabe43 → 0123456789abcdeffedcba9876543210, with `dp_grp` sequence 2,1,0 and `dp_rev`=1.
- ROUND_LAT=3: same vector → `out_valid` in cycle T+13; `dp_grp` holds each value for exactly 4 cycles.
- Hold `out_ready`=0 for 10 cycles → `out_blk` and `out_valid` stable, `in_ready`=0, a second `in_valid` is not accepted. Release `out_ready` → IDLE the next cycle; the second block is accepted and produces a correct result.
- Assert RST in the 2nd cycle of R1 → the next cycle shows IDLE, `out_valid`=0, `dp_in_l`=`dp_in_r`=0, `busy`=0. A fresh vector then completes correctly.
- Two blocks back-to-back with `out_ready`=1 → accepts spaced exactly 3·ROUND_LAT+5 cycles apart; both ciphertexts correct.
